// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: pulses the PLL reset, qualifies the synchronized
// lock signal and holds the core reset until the clocks are stable.
module pll_lock_sequencer #(
  parameter int RST_CYCLES  = 16,
  parameter int LOCK_FILT   = 1024,
  parameter int HOLD_CYCLES = 64,
  parameter int TIMEOUT     = 1048576,
  parameter int CNTW        = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       timeout_err,
  output logic [3:0] relock_cnt
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_FILTER,
    S_HOLD,
    S_RUN
  } state_t;

  localparam logic [CNTW-1:0] RST_LAST  = CNTW'(RST_CYCLES - 1);
  localparam logic [CNTW-1:0] FILT_LAST = CNTW'(LOCK_FILT - 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] TO_LAST   = CNTW'(TIMEOUT - 1);

  state_t          state;
  state_t          state_next;
  logic [CNTW-1:0] cnt;
  logic [1:0]      lock_sync;
  logic            lock_s;
  logic            timeout_hit;
  logic            run_exit;

  assign lock_s = lock_sync[1];

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    run_exit    = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = S_FILTER;
        end else if (cnt == TO_LAST) begin
          state_next  = S_RESET_PLL;
          timeout_hit = 1'b1;
        end
      end
      S_FILTER: begin
        if (!lock_s)               state_next = S_WAIT_LOCK;
        else if (cnt == FILT_LAST) state_next = S_HOLD;
      end
      S_HOLD: begin
        // Lock loss wins over an expiring hold window.
        if (!lock_s)               state_next = S_RESET_PLL;
        else if (cnt == HOLD_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (!lock_s || force_relock) begin
          state_next = S_RESET_PLL;
          run_exit   = 1'b1;
        end
      end
      default: state_next = S_RESET_PLL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      lock_sync   <= 2'b00;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      timeout_err <= 1'b0;
      relock_cnt  <= 4'd0;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      state     <= state_next;
      // No state loops back to itself, so any change of state is a fresh entry.
      if (state_next != state) cnt <= '0;
      else if (state != S_RUN) cnt <= cnt + CNTW'(1);
      pll_rst <= (state_next == S_RESET_PLL);
      sys_rst <= (state_next != S_RUN);
      ready   <= (state_next == S_RUN);
      if (timeout_hit) timeout_err <= 1'b1;
      if (run_exit && relock_cnt != 4'hF) relock_cnt <= relock_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expected values are queued as stimulus is
// applied and popped when the corresponding DUT behaviour is observed.
module tb_pll_lock_sequencer;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       timeout_err;
  logic [3:0] relock_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rst_hi = 0;
  int t0 = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  pll_lock_sequencer #(
    .RST_CYCLES (4),
    .LOCK_FILT  (8),
    .HOLD_CYCLES(4),
    .TIMEOUT    (100),
    .CNTW       (21)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .timeout_err (timeout_err),
    .relock_cnt  (relock_cnt)
  );

  always #5 clk = ~clk;

  // Every step lands 1 ns after a rising edge; inputs are driven and outputs sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pll_rst) rst_hi++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [W-1:0] out_vec();
    return W'({pll_rst, sys_rst, ready, timeout_err, relock_cnt});
  endfunction

  task automatic expect_val(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [W-1:0] obs);
    logic [W-1:0] e;
    string        t;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  // Bounded wait for pll_rst (use_ready=0) or ready (use_ready=1) to reach lvl.
  task automatic wait_sig(input bit use_ready, input logic lvl, input int limit);
    int n;
    n = 0;
    while (((use_ready ? ready : pll_rst) !== lvl) && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_force();
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
  endtask

  initial begin
    // 1. clean power-up
    pll_locked = 1'b1;
    ticks(3);
    expect_val("reset_outputs", 32'hC0);
    compare(out_vec());
    rst = 1'b0;
    t0 = cyc;
    expect_val("pwr_pll_rst_width", 32'd4);
    wait_sig(1'b0, 1'b0, 50);
    compare(W'(cyc - t0));
    expect_val("pwr_ready_delay", 32'd17);
    wait_sig(1'b1, 1'b1, 100);
    compare(W'(cyc - t0));
    expect_val("pwr_run_outputs", 32'h20);
    compare(out_vec());

    // 2. one-cycle lock glitch 5 cycles into FILTER (FILTER entered at edge 5)
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    t0 = cyc;
    ticks(9);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    rst_hi = 0;
    expect_val("glitch_ready_delay", 32'd25);
    wait_sig(1'b1, 1'b1, 100);
    compare(W'(cyc - t0));
    expect_val("glitch_no_pll_rst", 32'd0);
    compare(W'(rst_hi));

    // 3. no lock: 4-cycle PLL reset every 104 cycles
    rst = 1'b1;
    pll_locked = 1'b0;
    ticks(2);
    rst = 1'b0;
    t0 = cyc;
    expect_val("to_first_fall", 32'd4);
    wait_sig(1'b0, 1'b0, 50);
    compare(W'(cyc - t0));
    expect_val("to_first_retry", 32'd104);
    wait_sig(1'b0, 1'b1, 200);
    compare(W'(cyc - t0));
    expect_val("to_err_outputs", 32'hD0);
    compare(out_vec());
    expect_val("to_retry_fall", 32'd108);
    wait_sig(1'b0, 1'b0, 50);
    compare(W'(cyc - t0));
    expect_val("to_second_retry", 32'd208);
    wait_sig(1'b0, 1'b1, 200);
    compare(W'(cyc - t0));
    pll_locked = 1'b1;
    expect_val("to_lock_ready", 32'd225);
    wait_sig(1'b1, 1'b1, 100);
    compare(W'(cyc - t0));
    expect_val("to_err_sticky", 32'h30);
    compare(out_vec());

    // 4. lock loss in RUN: synchronizer takes 2 edges, the FSM reacts on the third
    t0 = cyc;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    expect_val("loss_ready_drop", 32'd3);
    wait_sig(1'b1, 1'b0, 20);
    compare(W'(cyc - t0));
    expect_val("loss_outputs", 32'hD1);
    compare(out_vec());
    expect_val("loss_pll_rst_fall", 32'd7);
    wait_sig(1'b0, 1'b0, 20);
    compare(W'(cyc - t0));
    expect_val("loss_ready_again", 32'd20);
    wait_sig(1'b1, 1'b1, 100);
    compare(W'(cyc - t0));
    expect_val("loss_run_outputs", 32'h31);
    compare(out_vec());

    // 5a. force_relock in RUN, then again while in HOLD (ignored, not remembered)
    t0 = cyc;
    pulse_force();
    expect_val("force_exit_outputs", 32'hD2);
    compare(out_vec());
    ticks(14);
    pulse_force();
    expect_val("hold_force_ready", 32'd18);
    wait_sig(1'b1, 1'b1, 100);
    compare(W'(cyc - t0));
    ticks(3);
    expect_val("hold_force_ignored", 32'h32);
    compare(out_vec());

    // 5b. lock loss and force_relock reaching the FSM on the same edge
    t0 = cyc;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    pulse_force();
    expect_val("coincident_single_inc", 32'hD3);
    compare(out_vec());

    // 6. reset asserted while in HOLD (HOLD spans t0+16 .. t0+20)
    ticks(14);
    expect_val("hold_outputs", 32'h53);
    compare(out_vec());
    rst = 1'b1;
    tick();
    expect_val("mid_reset_outputs", 32'hC0);
    compare(out_vec());
    rst = 1'b0;
    t0 = cyc;
    expect_val("restart_pll_rst_width", 32'd4);
    wait_sig(1'b0, 1'b0, 50);
    compare(W'(cyc - t0));
    expect_val("restart_ready_delay", 32'd17);
    wait_sig(1'b1, 1'b1, 100);
    compare(W'(cyc - t0));
    expect_val("restart_run_outputs", 32'h20);
    compare(out_vec());

    // 5c. 16 relock requests: counter saturates at 15
    for (int k = 1; k <= 16; k++) begin
      t0 = cyc;
      pulse_force();
      expect_val($sformatf("sat_relock_%0d", k), W'((k > 15) ? 15 : k));
      compare(W'(relock_cnt));
      expect_val($sformatf("sat_ready_%0d", k), 32'd18);
      wait_sig(1'b1, 1'b1, 100);
      compare(W'(cyc - t0));
    end
    expect_val("sat_final_outputs", 32'h2F);
    compare(out_vec());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Power-up and recovery sequencer for the system PLL that generates the 48/96 MHz core and SDRAM clocks. It drives the PLL reset input and watches the PLL lock output, which is asynchronous to this block. It filters lock glitches and holds the core reset until the clocks have been stable for a programmed time. It runs on the free-running board reference clock. If lock is lost or a relock is requested, it resets the PLL again and counts the event.

Parameters:
RST_CYCLES, 16, width in clk cycles of each PLL reset pulse (>=2)
LOCK_FILT, 1024, consecutive synchronized-lock cycles required before lock is accepted (>=1)
HOLD_CYCLES, 64, cycles sys_rst stays high after lock is accepted (>=1)
TIMEOUT, 1048576, max cycles spent in WAIT_LOCK before the PLL is reset again (>=2)
CNTW, 21, width of the shared state counter; must hold max(parameters)-1

Ports:
clk  in  1  board reference clock (free running, never gated by the PLL)
rst  in  1  synchronous active-high reset
pll_locked  in  1  PLL lock output, asynchronous to clk
force_relock  in  1  single-cycle request to re-run the PLL sequence; honoured only in RUN
pll_rst  out  1  PLL reset input drive
sys_rst  out  1  core reset, high until clocks are qualified
ready  out  1  high only in RUN
timeout_err  out  1  sticky; set on any WAIT_LOCK timeout
relock_cnt  out  4  saturating count of exits from RUN

Behaviour:
- Reset values (while rst=1): state=RESET_PLL, cnt=0, pll_rst=1, sys_rst=1, ready=0, timeout_err=0, relock_cnt=0, lock synchronizer=00.
- pll_locked passes through a 2-flop synchronizer; lock_s is the second flop. lock_s is pll_locked delayed by 2 cycles.
- Timing convention:
  - cnt clears to 0 on every state entry and increments each cycle in the state.
  - "after N cycles" means the transition happens on the edge where cnt==N-1, so the state lasts exactly N cycles.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- States:
  - RESET_PLL: pll_rst=1. lock_s is ignored. After RST_CYCLES cycles -> WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0.
    - lock_s=1 -> FILTER.
    - Otherwise, after TIMEOUT cycles -> RESET_PLL and set timeout_err.
  - FILTER: pll_rst=0.
    - lock_s=0 in any cycle -> WAIT_LOCK; the timeout window restarts from 0.
    - After LOCK_FILT cycles with lock_s=1 throughout -> HOLD.
  - HOLD: pll_rst=0, sys_rst=1.
    - lock_s=0 -> RESET_PLL.
    - After HOLD_CYCLES cycles -> RUN.
  - RUN: sys_rst=0, ready=1, pll_rst=0.
    - lock_s=0 or force_relock=1 -> RESET_PLL.
    - relock_cnt increments on that edge and saturates at 15.
- sys_rst=1 and ready=0 in every state except RUN.
- Simultaneous events in RUN: lock loss and force_relock in the same cycle count as one exit (single increment).
- In HOLD, a lock drop on the same edge as the HOLD_CYCLES expiry takes priority; the block goes to RESET_PLL, not RUN.
- force_relock outside RUN is ignored and not remembered.
- rst asserted mid-sequence returns everything to reset values on the next edge, including timeout_err and relock_cnt.
- No combinational path from pll_locked or force_relock to any output.

Test Plan:
Use RST_CYCLES=4, LOCK_FILT=8, HOLD_CYCLES=4, TIMEOUT=100 for all scenarios.
1. Clean power-up: pll_locked held 1, rst released -> pll_rst high exactly 4 cycles; ready rises and sys_rst falls 17 cycles after rst release (4+1+8+4); timeout_err=0.
2. Glitch filter: pll_locked=1, then a 1-cycle 0 pulse 5 cycles into FILTER -> FILTER exits to WAIT_LOCK and restarts; ready is delayed accordingly; pll_rst never reasserts.
3. Timeout retry: pll_locked held 0 -> pll_rst pulses for 4 cycles every 104 cycles; timeout_err=1 after the first expiry and stays set after lock later succeeds.
4. Lock loss in RUN: drop pll_locked for 1 cycle -> 2 cycles later sys_rst=1, ready=0, pll_rst=1 for 4 cycles; relock_cnt=1; sequence completes again.
5. force_relock: pulse in RUN 16 times -> relock_cnt saturates at 15; pulse during HOLD -> no effect; pulse coincident with lock loss -> single increment.
6. Reset mid-operation: assert rst in HOLD with relock_cnt=3 and timeout_err=1 -> next edge all outputs at reset values; the sequence restarts from RESET_PLL.
